// File: rtl/stream_extrema_tracker_pkg.sv
// Shared FSM state encoding and width constants for the extrema tracker.
package stream_extrema_tracker_pkg;

  localparam int SAMPLE_W      = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/stream_extrema_tracker_cmp.sv
// 4-bit unsigned magnitude comparator: exactly one of gt/eq/lt is set for A vs B.
module Four_bit_compartor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  always_comb begin
    gt = (A > B);
    eq = (A == B);
    lt = (A < B);
  end

endmodule

// File: rtl/stream_extrema_tracker.sv
// Framed stream consumer tracking running max/min, max occurrence count and frame length,
// presenting one registered result per frame over a valid/ready handshake.
module stream_extrema_tracker
  import stream_extrema_tracker_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_max_cnt,
  output logic [CNT_W-1:0] out_len,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] max_q, min_q;
  logic [CNT_W-1:0] max_cnt_q, len_q;
  logic             sat_q;

  logic max_gt, max_eq, max_lt;
  logic min_gt, min_eq, min_lt;
  logic in_accept, out_accept;
  logic len_full, cnt_full;
  logic unused_cmp_bits;

  Four_bit_compartor u_cmp_max (
    .A  (in_data),
    .B  (max_q),
    .gt (max_gt),
    .eq (max_eq),
    .lt (max_lt)
  );

  Four_bit_compartor u_cmp_min (
    .A  (in_data),
    .B  (min_q),
    .gt (min_gt),
    .eq (min_eq),
    .lt (min_lt)
  );

  assign unused_cmp_bits = &{1'b0, max_lt, min_gt, min_eq};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    in_accept  = 1'b0;
    out_accept = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ACC: begin
        in_ready  = 1'b1;
        in_accept = in_valid;
        if (in_valid) state_d = in_last ? ST_HOLD : ST_ACC;
      end
      ST_HOLD: begin
        out_valid  = 1'b1;
        out_accept = out_ready;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign len_full = (len_q == CNT_MAX);
  assign cnt_full = (max_cnt_q == CNT_MAX);

  // The first beat of a frame seeds every register directly; later beats
  // consult the comparators, and counters saturate while flagging sat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_q     <= '0;
      min_q     <= '0;
      max_cnt_q <= '0;
      len_q     <= '0;
      sat_q     <= 1'b0;
    end else if (in_accept) begin
      if (state_q == ST_IDLE) begin
        max_q     <= in_data;
        min_q     <= in_data;
        max_cnt_q <= CNT_ONE;
        len_q     <= CNT_ONE;
        sat_q     <= 1'b0;
      end else begin
        if (max_gt) begin
          max_q     <= in_data;
          max_cnt_q <= CNT_ONE;
        end else if (max_eq && !cnt_full) begin
          max_cnt_q <= max_cnt_q + CNT_ONE;
        end
        if (min_lt) min_q <= in_data;
        if (!len_full) len_q <= len_q + CNT_ONE;
        sat_q <= sat_q | len_full | (max_eq & cnt_full);
      end
    end
  end

  assign out_max     = max_q;
  assign out_min     = min_q;
  assign out_max_cnt = max_cnt_q;
  assign out_len     = len_q;
  assign out_sat     = sat_q;

  logic unused_accept;
  assign unused_accept = out_accept;

endmodule

// File: tb/tb_stream_extrema_tracker.sv
// Self-checking bench: table of frames plus hand sequences, results checked via scoreboard queues.
module tb_stream_extrema_tracker;

  typedef struct packed {
    logic [3:0] mx;
    logic [3:0] mn;
    logic [7:0] cnt;
    logic [7:0] len;
    logic       sat;
  } res_t;

  typedef struct {
    int          n;
    logic [47:0] d;
    res_t        exp;
  } vec_t;

  logic clk, rst_n;
  logic in_valid, in_last, out_ready;
  logic [3:0] in_data;
  logic in_ready, out_valid, out_sat;
  logic [3:0] out_max, out_min;
  logic [7:0] out_max_cnt, out_len;

  logic i3_valid, i3_last;
  logic [3:0] i3_data;
  logic i3_ready, o3_valid, o3_sat;
  logic [3:0] o3_max, o3_min;
  logic [2:0] o3_cnt, o3_len;

  int n_cmp = 0;
  int n_bad = 0;
  res_t q8[$];
  res_t q3[$];
  vec_t tv[6];

  stream_extrema_tracker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min), .out_max_cnt(out_max_cnt),
    .out_len(out_len), .out_sat(out_sat)
  );

  stream_extrema_tracker #(.WIDTH(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i3_valid), .in_ready(i3_ready), .in_data(i3_data), .in_last(i3_last),
    .out_valid(o3_valid), .out_ready(out_ready),
    .out_max(o3_max), .out_min(o3_min), .out_max_cnt(o3_cnt),
    .out_len(o3_len), .out_sat(o3_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t mk(input int mx, input int mn, input int cnt, input int len,
                              input int sat);
    res_t r;
    r.mx  = 4'(mx);
    r.mn  = 4'(mn);
    r.cnt = 8'(cnt);
    r.len = 8'(len);
    r.sat = sat[0];
    return r;
  endfunction

  // Entered and left at posedge+1; returns after the accepting edge with valid dropped.
  task automatic send_beat(input bit sel, input logic [3:0] d, input bit last,
                           output int waited);
    int k;
    k = 0;
    if (sel) begin
      i3_valid = 1'b1; i3_data = d; i3_last = last;
    end else begin
      in_valid = 1'b1; in_data = d; in_last = last;
    end
    while (((sel ? i3_ready : in_ready) == 1'b0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) chk("in_ready_timeout", k, 0);
    waited = k;
    @(posedge clk); #1;
    if (sel) i3_valid = 1'b0;
    else     in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int w;
    res_t e;

    tv[0].n = 5; tv[0].d = 48'h49193;   tv[0].exp = mk(9, 1, 2, 5, 0);
    tv[1].n = 1; tv[1].d = 48'h7;       tv[1].exp = mk(7, 7, 1, 1, 0);
    tv[2].n = 4; tv[2].d = 48'h5555;    tv[2].exp = mk(5, 5, 4, 4, 0);
    tv[3].n = 2; tv[3].d = 48'hF0;      tv[3].exp = mk(15, 0, 1, 2, 0);
    tv[4].n = 5; tv[4].d = 48'hFE0FF;   tv[4].exp = mk(15, 0, 3, 5, 0);
    tv[5].n = 7; tv[5].d = 48'h2CC1C38; tv[5].exp = mk(12, 1, 3, 7, 0);

    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    i3_valid = 1'b0; i3_data = '0; i3_last = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (q8.size() == 0) chk("unexpected_result", q8.size(), 1);
          else begin
            e = q8.pop_front();
            chk("out_max", int'(out_max), int'(e.mx));
            chk("out_min", int'(out_min), int'(e.mn));
            chk("out_max_cnt", int'(out_max_cnt), int'(e.cnt));
            chk("out_len", int'(out_len), int'(e.len));
            chk("out_sat", int'(out_sat), int'(e.sat));
          end
        end
      end
      forever begin
        @(negedge clk);
        if (o3_valid && out_ready) begin
          if (q3.size() == 0) chk("unexpected_result3", q3.size(), 1);
          else begin
            res_t e3;
            e3 = q3.pop_front();
            chk("o3_max", int'(o3_max), int'(e3.mx));
            chk("o3_min", int'(o3_min), int'(e3.mn));
            chk("o3_max_cnt", int'(o3_cnt), int'(e3.cnt));
            chk("o3_len", int'(o3_len), int'(e3.len));
            chk("o3_sat", int'(o3_sat), int'(e3.sat));
          end
        end
      end
    join_none

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_max", int'(out_max), 0);
    chk("rst_out_min", int'(out_min), 0);
    chk("rst_out_cnt", int'(out_max_cnt), 0);
    chk("rst_out_len", int'(out_len), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_o3_valid", int'(o3_valid), 0);
    rst_n = 1'b1;
    idle_cycles(1);

    // table frames with latency and HOLD-state checks
    for (int i = 0; i < 6; i++) begin
      q8.push_back(tv[i].exp);
      for (int j = 0; j < tv[i].n; j++) begin
        logic [3:0] s;
        s = tv[i].d[j*4 +: 4];
        if (j == tv[i].n - 1 && j > 0) chk("pre_last_out_valid", int'(out_valid), 0);
        send_beat(1'b0, s, (j == tv[i].n - 1), w);
      end
      chk("post_last_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    idle_cycles(2);

    // backpressure: result held stable, inputs ignored, no same-cycle turnaround
    out_ready = 1'b0;
    q8.push_back(mk(6, 2, 1, 2, 0));
    send_beat(1'b0, 4'd6, 1'b0, w);
    send_beat(1'b0, 4'd2, 1'b1, w);
    in_valid = 1'b1; in_data = 4'd9; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_max", int'(out_max), 6);
      chk("bp_out_min", int'(out_min), 2);
      chk("bp_out_len", int'(out_len), 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_in_ready", int'(in_ready), 1);
    chk("bp_after_out_valid", int'(out_valid), 0);
    chk("bp_after_hold_max", int'(out_max), 6);
    q8.push_back(mk(4, 4, 1, 1, 0));
    send_beat(1'b0, 4'd4, 1'b1, w);
    chk("turnaround_wait", w, 0);
    idle_cycles(2);

    // saturation on the narrow-counter instance, then sat clears on the next frame
    q3.push_back(mk(15, 15, 7, 7, 1));
    for (int j = 0; j < 10; j++) send_beat(1'b1, 4'd15, (j == 9), w);
    q3.push_back(mk(2, 0, 1, 2, 0));
    send_beat(1'b1, 4'd2, 1'b0, w);
    send_beat(1'b1, 4'd0, 1'b1, w);
    idle_cycles(2);

    // reset mid-frame drops the partial frame
    send_beat(1'b0, 4'd1, 1'b0, w);
    send_beat(1'b0, 4'd2, 1'b0, w);
    send_beat(1'b0, 4'd3, 1'b0, w);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    idle_cycles(1);
    q8.push_back(mk(5, 5, 1, 1, 0));
    send_beat(1'b0, 4'd5, 1'b1, w);
    idle_cycles(2);

    // valid gaps between beats do not disturb the counters
    q8.push_back(mk(15, 0, 1, 3, 0));
    send_beat(1'b0, 4'd0, 1'b0, w);
    idle_cycles(2);
    send_beat(1'b0, 4'd15, 1'b0, w);
    idle_cycles(1);
    send_beat(1'b0, 4'd8, 1'b1, w);

    for (int c = 0; c < 50 && (q8.size() != 0 || q3.size() != 0); c++) idle_cycles(1);
    idle_cycles(3);
    chk("q8_drained", q8.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
